// File: rtl/mprf_ordbuf.sv
// Multi-port register file fronted by an ordered write-back buffer: exec results wait until
// their count of older unreleased memory ops reaches zero, then drain to the file.
module mprf_ordbuf #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RGBIT     = 5,
    parameter int unsigned EXEC_LEN  = 4,
    parameter int unsigned RD_PORTS  = 8,
    parameter int unsigned RFBUF_LEN = 8,
    parameter int unsigned WB_PORTS  = 2,
    parameter int unsigned MEM_PORTS = 2,
    parameter int unsigned ORD_W     = 3,
    localparam int unsigned NUM_W    = $clog2(RFBUF_LEN + 1),
    localparam int unsigned REL_W    = $clog2(MEM_PORTS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [EXEC_LEN*RGBIT-1:0]     rd_sel_i,
    input  logic [EXEC_LEN*ORD_W-1:0]     rd_order_i,
    input  logic [EXEC_LEN*XLEN-1:0]      rd_data_i,
    input  logic [RD_PORTS*RGBIT-1:0]     rs_sel_i,
    output logic [RD_PORTS*XLEN-1:0]      rs_data_o,
    input  logic [MEM_PORTS-1:0]          mem_vld_i,
    input  logic [MEM_PORTS*RGBIT-1:0]    mem_sel_i,
    input  logic [MEM_PORTS*XLEN-1:0]     mem_data_i,
    input  logic [REL_W-1:0]              mem_rel_num_i,
    input  logic                          clear_pipeline_i,
    output logic [NUM_W-1:0]              rf_num_o,
    output logic [NUM_W-1:0]              rf_free_o,
    output logic                          ovf_err_o
);

    localparam int unsigned NREG   = 1 << RGBIT;
    localparam int unsigned CAND_N = RFBUF_LEN + EXEC_LEN;
    localparam int unsigned IDX_W  = (RFBUF_LEN > 1) ? $clog2(RFBUF_LEN) : 1;

    logic [XLEN-1:0]  rf_q   [NREG];
    logic [XLEN-1:0]  rf_d   [NREG];
    logic [RGBIT-1:0] bsel_q [RFBUF_LEN];
    logic [RGBIT-1:0] bsel_d [RFBUF_LEN];
    logic [ORD_W-1:0] bord_q [RFBUF_LEN];
    logic [ORD_W-1:0] bord_d [RFBUF_LEN];
    logic [XLEN-1:0]  bdat_q [RFBUF_LEN];
    logic [XLEN-1:0]  bdat_d [RFBUF_LEN];
    logic [NUM_W-1:0] num_q, num_d, free_q;
    logic             ovf_q, ovf_d;

    logic             c_vld [CAND_N];
    logic [RGBIT-1:0] c_sel [CAND_N];
    logic [ORD_W-1:0] c_ord [CAND_N];
    logic [XLEN-1:0]  c_dat [CAND_N];

    int unsigned drn_cnt;
    int unsigned keep_cnt;

    // Saturating decrement of a pending-order count by the release count.
    function automatic logic [ORD_W-1:0] ord_upd(input logic [ORD_W-1:0] ord,
                                                 input logic [REL_W-1:0] rel);
        int unsigned o;
        int unsigned r;
        o = 32'(ord);
        r = 32'(rel);
        if (r >= o) return '0;
        return ORD_W'(o - r);
    endfunction

    // Candidate list, oldest first: buffer slots, then lanes in ascending order.
    always_comb begin
        for (int unsigned i = 0; i < RFBUF_LEN; i++) begin
            c_vld[i] = (NUM_W'(i) < num_q);
            c_sel[i] = bsel_q[i];
            c_ord[i] = ord_upd(bord_q[i], mem_rel_num_i);
            c_dat[i] = bdat_q[i];
        end
        for (int unsigned l = 0; l < EXEC_LEN; l++) begin
            c_sel[RFBUF_LEN+l] = rd_sel_i[l*RGBIT +: RGBIT];
            c_vld[RFBUF_LEN+l] = (rd_sel_i[l*RGBIT +: RGBIT] != '0);
            c_ord[RFBUF_LEN+l] = ord_upd(rd_order_i[l*ORD_W +: ORD_W], mem_rel_num_i);
            c_dat[RFBUF_LEN+l] = rd_data_i[l*XLEN +: XLEN];
        end
    end

    // Drain, keep/compact, overflow and file-write resolution.
    always_comb begin
        rf_d     = rf_q;
        bsel_d   = bsel_q;
        bord_d   = bord_q;
        bdat_d   = bdat_q;
        ovf_d    = ovf_q;
        drn_cnt  = 0;
        keep_cnt = 0;
        for (int unsigned c = 0; c < CAND_N; c++) begin
            if (c < RFBUF_LEN && c_vld[c] && c_ord[c] == '0 && drn_cnt < WB_PORTS) begin
                rf_d[c_sel[c]] = c_dat[c];
                drn_cnt        = drn_cnt + 1;
            end else if (c_vld[c] && !(clear_pipeline_i && c_ord[c] != '0)) begin
                if (keep_cnt < RFBUF_LEN) begin
                    bsel_d[IDX_W'(keep_cnt)] = c_sel[c];
                    bord_d[IDX_W'(keep_cnt)] = c_ord[c];
                    bdat_d[IDX_W'(keep_cnt)] = c_dat[c];
                end else begin
                    ovf_d = 1'b1;
                end
                keep_cnt = keep_cnt + 1;
            end
        end
        // Memory ports override drains; the higher port index wins.
        for (int unsigned m = 0; m < MEM_PORTS; m++) begin
            if (mem_vld_i[m]) rf_d[mem_sel_i[m*RGBIT +: RGBIT]] = mem_data_i[m*XLEN +: XLEN];
        end
        rf_d[0] = '0;
        num_d   = (keep_cnt > RFBUF_LEN) ? NUM_W'(RFBUF_LEN) : NUM_W'(keep_cnt);
    end

    // Reads: youngest matching buffer entry forwards, else the file; x0 reads zero.
    always_comb begin
        rs_data_o = '0;
        for (int unsigned p = 0; p < RD_PORTS; p++) begin
            rs_data_o[p*XLEN +: XLEN] = rf_q[rs_sel_i[p*RGBIT +: RGBIT]];
            for (int unsigned i = 0; i < RFBUF_LEN; i++) begin
                if (NUM_W'(i) < num_q && bsel_q[i] == rs_sel_i[p*RGBIT +: RGBIT])
                    rs_data_o[p*XLEN +: XLEN] = bdat_q[i];
            end
            if (rs_sel_i[p*RGBIT +: RGBIT] == '0) rs_data_o[p*XLEN +: XLEN] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) rf_q[r] <= '0;
            for (int unsigned i = 0; i < RFBUF_LEN; i++) begin
                bsel_q[i] <= '0;
                bord_q[i] <= '0;
                bdat_q[i] <= '0;
            end
            num_q  <= '0;
            free_q <= NUM_W'(RFBUF_LEN);
            ovf_q  <= 1'b0;
        end else begin
            rf_q   <= rf_d;
            bsel_q <= bsel_d;
            bord_q <= bord_d;
            bdat_q <= bdat_d;
            num_q  <= num_d;
            free_q <= NUM_W'(RFBUF_LEN) - num_d;
            ovf_q  <= ovf_d;
        end
    end

    assign rf_num_o  = num_q;
    assign rf_free_o = free_q;
    assign ovf_err_o = ovf_q;

endmodule

// File: tb/tb_mprf_ordbuf.sv
// Bench for mprf_ordbuf: directed scenarios plus random traffic, checked against a
// queue-based model of the buffer and an array model of the register file.
module tb_mprf_ordbuf;

    localparam int unsigned RFBUF = 8;
    localparam int unsigned WB    = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [19:0]  rd_sel;
    logic [11:0]  rd_order;
    logic [127:0] rd_data;
    logic [39:0]  rs_sel;
    logic [255:0] rs_data;
    logic [1:0]   mem_vld;
    logic [9:0]   mem_sel;
    logic [63:0]  mem_data;
    logic [1:0]   mem_rel;
    logic         clear;
    logic [3:0]   rf_num, rf_free;
    logic         ovf;

    mprf_ordbuf dut (
        .clk              (clk),
        .rst              (rst),
        .rd_sel_i         (rd_sel),
        .rd_order_i       (rd_order),
        .rd_data_i        (rd_data),
        .rs_sel_i         (rs_sel),
        .rs_data_o        (rs_data),
        .mem_vld_i        (mem_vld),
        .mem_sel_i        (mem_sel),
        .mem_data_i       (mem_data),
        .mem_rel_num_i    (mem_rel),
        .clear_pipeline_i (clear),
        .rf_num_o         (rf_num),
        .rf_free_o        (rf_free),
        .ovf_err_o        (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        int          ord;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mfile[32];
    logic        movf;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mread(input int sel);
        if (sel == 0) return 32'h0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].sel == sel) return mq[i].data;
        return mfile[sel];
    endfunction

    // Reference behaviour for one clock, from the current inputs.
    task automatic model_step();
        ent_t        c[$];
        ent_t        k[$];
        ent_t        e;
        int          nbuf;
        int          ndrn;
        int          rel;
        logic [31:0] nf[32];
        if (rst) begin
            mq.delete();
            foreach (mfile[r]) mfile[r] = 32'h0;
            movf = 1'b0;
            return;
        end
        rel  = int'(mem_rel);
        nbuf = mq.size();
        foreach (mq[i]) begin
            e = mq[i];
            e.ord = (e.ord > rel) ? e.ord - rel : 0;
            c.push_back(e);
        end
        for (int l = 0; l < 4; l++) begin
            e.sel  = int'(rd_sel[l*5 +: 5]);
            e.ord  = int'(rd_order[l*3 +: 3]);
            e.ord  = (e.ord > rel) ? e.ord - rel : 0;
            e.data = rd_data[l*32 +: 32];
            if (e.sel != 0) c.push_back(e);
        end
        nf   = mfile;
        ndrn = 0;
        foreach (c[i]) begin
            if (i < nbuf && c[i].ord == 0 && ndrn < WB) begin
                nf[c[i].sel] = c[i].data;
                ndrn++;
            end else if (!(clear && c[i].ord != 0)) begin
                k.push_back(c[i]);
            end
        end
        for (int m = 0; m < 2; m++)
            if (mem_vld[m]) nf[mem_sel[m*5 +: 5]] = mem_data[m*32 +: 32];
        nf[0] = 32'h0;
        if (k.size() > RFBUF) movf = 1'b1;
        while (k.size() > RFBUF) void'(k.pop_back());
        mq    = k;
        mfile = nf;
    endtask

    task automatic idle();
        rst = 1'b0; rd_sel = '0; rd_order = '0; rd_data = '0;
        mem_vld = '0; mem_sel = '0; mem_data = '0; mem_rel = '0; clear = 1'b0;
    endtask

    task automatic set_lane(input int l, input int sel, input int ord, input logic [31:0] d);
        rd_sel[l*5 +: 5]    = 5'(sel);
        rd_order[l*3 +: 3]  = 3'(ord);
        rd_data[l*32 +: 32] = d;
    endtask

    // One clock: check reads before the edge, advance model, check registered outputs after.
    task automatic cycle();
        #1;
        for (int p = 0; p < 8; p++)
            chk($sformatf("rs%0d_x%0d", p, rs_sel[p*5 +: 5]), rs_data[p*32 +: 32],
                mread(int'(rs_sel[p*5 +: 5])));
        model_step();
        @(posedge clk);
        #1;
        chk("rf_num", 32'(rf_num), 32'(mq.size()));
        chk("rf_free", 32'(rf_free), 32'(RFBUF - mq.size()));
        chk("ovf_err", 32'(ovf), 32'(movf));
        idle();
    endtask

    task automatic rd_chk(input string tag, input int sel, input logic [31:0] exp);
        rs_sel[4:0] = 5'(sel);
        #1;
        chk(tag, rs_data[31:0], exp);
    endtask

    initial begin
        int nact;
        idle();
        rs_sel = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_step();
        rst = 1'b0;
        chk("reset_num", 32'(rf_num), 32'd0);
        chk("reset_free", 32'(rf_free), 32'd8);
        chk("reset_ovf", 32'(ovf), 32'd0);
        for (int p = 0; p < 8; p++) rs_sel[p*5 +: 5] = 5'(p * 4 + 1);
        #1;
        for (int p = 0; p < 8; p++) chk("reset_rs", rs_data[p*32 +: 32], 32'h0);

        // 1: zero-order result buffers one cycle, then drains
        set_lane(0, 5, 0, 32'hA);
        cycle();
        chk("t1_num1", 32'(rf_num), 32'd1);
        rd_chk("t1_rs5_buf", 5, 32'hA);
        cycle();
        chk("t1_num0", 32'(rf_num), 32'd0);
        rd_chk("t1_rs5_file", 5, 32'hA);

        // 2: ordered result waits for two releases
        set_lane(0, 3, 2, 32'h11);
        cycle();
        mem_rel = 2'd1;
        cycle();
        chk("t2_wait", 32'(rf_num), 32'd1);
        mem_rel = 2'd1;
        cycle();
        chk("t2_drained", 32'(rf_num), 32'd0);
        rd_chk("t2_rs3", 3, 32'h11);

        // 3: three ready entries, two drain; same-reg drains keep the younger value
        set_lane(0, 7, 0, 32'h1);
        set_lane(1, 7, 0, 32'h3);
        set_lane(2, 10, 0, 32'h2);
        cycle();
        cycle();
        chk("t3_one_left", 32'(rf_num), 32'd1);
        rd_chk("t3_rs7", 7, 32'h3);
        cycle();

        // 4: flush drops speculative entries, ready one still drains
        set_lane(0, 4, 0, 32'h44);
        set_lane(1, 6, 1, 32'h66);
        cycle();
        clear = 1'b1;
        set_lane(0, 8, 1, 32'h88);
        cycle();
        chk("t4_num", 32'(rf_num), 32'd0);
        rd_chk("t4_rs4", 4, 32'h44);
        rd_chk("t4_rs6", 6, mfile[6]);
        rd_chk("t4_rs8", 8, mfile[8]);

        // 5: mem port priority over drain, then overflow
        set_lane(0, 9, 0, 32'h99);
        cycle();
        mem_vld = 2'b11;
        mem_sel = {5'd9, 5'd9};
        mem_data = {32'h2, 32'h1};
        cycle();
        rd_chk("t5_rs9", 9, 32'h2);
        for (int b = 0; b < 3; b++) begin
            for (int l = 0; l < 4; l++) set_lane(l, 11 + b * 4 + l, 3, 32'h100 + 32'(b * 4 + l));
            cycle();
        end
        chk("t5_ovf", 32'(ovf), 32'd1);
        chk("t5_full", 32'(rf_num), 32'd8);
        rd_chk("t5_lost", 22, mfile[22]);

        // 6: idle x0 lane, then reset with full buffer
        set_lane(0, 0, 0, 32'hDEAD);
        rs_sel = '0;
        cycle();
        rd_chk("t6_rs0", 0, 32'h0);
        rst = 1'b1;
        set_lane(0, 12, 0, 32'h5);
        mem_vld = 2'b01;
        mem_sel = 10'd13;
        mem_data = 64'h77;
        cycle();
        chk("t6_rst_num", 32'(rf_num), 32'd0);
        chk("t6_rst_ovf", 32'(ovf), 32'd0);
        rd_chk("t6_rs13", 13, 32'h0);
        rd_chk("t6_rs12", 12, 32'h0);

        // Random traffic within the advertised free count
        for (int n = 0; n < 600; n++) begin
            nact = $urandom_range(0, 4);
            if (nact > RFBUF - mq.size()) nact = RFBUF - mq.size();
            for (int l = 0; l < nact; l++)
                set_lane(l, $urandom_range(1, 15), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 4),
                         $urandom);
            mem_rel = 2'($urandom_range(0, 2));
            for (int m = 0; m < 2; m++) begin
                mem_vld[m] = ($urandom_range(0, 3) == 0);
                mem_sel[m*5 +: 5] = 5'($urandom_range(0, 15));
                mem_data[m*32 +: 32] = $urandom;
            end
            clear = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 149) == 0);
            for (int p = 0; p < 8; p++) rs_sel[p*5 +: 5] = 5'($urandom_range(0, 15));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
